// File: rtl/lut_neuron_prog.sv
// lut_neuron_prog: runtime-programmable LUT neuron.
// A configuration stream fills a 2^IN_BITS x OUT_BITS distributed-RAM table,
// after which the block serves registered one-cycle lookups from it.
// Optional build macro: LUT_CFG_CHECKSUM_EN (appends an XOR checksum word to
// every load and adds the cfg_err output).
module lut_neuron_prog #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2,
  parameter int CFG_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic [CFG_W-1:0]    cfg_data,
  output logic                cfg_ready,
  output logic                cfg_done,
  output logic                programmed,
`ifdef LUT_CFG_CHECKSUM_EN
  output logic                cfg_err,
`endif
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data
);

  localparam int DEPTH  = 1 << IN_BITS;
  localparam int EPW    = CFG_W / OUT_BITS;
  localparam int NWORDS = DEPTH / EPW;
  localparam int WCNT_W = $clog2(NWORDS + 1);
`ifdef LUT_CFG_CHECKSUM_EN
  localparam int LAST_WORD = NWORDS;
`else
  localparam int LAST_WORD = NWORDS - 1;
`endif

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    RUN
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [WCNT_W-1:0]   wcnt;
  logic [OUT_BITS-1:0] table_mem [DEPTH];
  logic                accept;
  logic                last_word;
  logic                data_word;
  logic [IN_BITS-1:0]  wr_base;
`ifdef LUT_CFG_CHECKSUM_EN
  logic [CFG_W-1:0]    csum;
  logic                csum_ok;
`endif

  // cfg_start takes priority, so a word presented alongside it is never consumed
  assign cfg_ready = (state == LOAD);
  assign accept    = cfg_ready && cfg_valid && !cfg_start;
  assign last_word = (wcnt == WCNT_W'(LAST_WORD));
  assign data_word = (wcnt < WCNT_W'(NWORDS));
  assign wr_base   = IN_BITS'(int'(wcnt) * EPW);
`ifdef LUT_CFG_CHECKSUM_EN
  assign csum_ok   = (cfg_data == csum);
`endif

  // Table write: each accepted data word fills EPW consecutive entries, entry 0 in the LSBs
  always_ff @(posedge clk) begin
    if (accept && data_word) begin
      for (int j = 0; j < EPW; j++) begin
        table_mem[wr_base + IN_BITS'(j)] <= cfg_data[j*OUT_BITS +: OUT_BITS];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: cfg_start always restarts a load, the final word ends it
  always_comb begin
    next_state = state;
    case (state)
      EMPTY: begin
        if (cfg_start) next_state = LOAD;
      end
      LOAD: begin
        if (cfg_start) begin
          next_state = LOAD;
        end else if (accept && last_word) begin
`ifdef LUT_CFG_CHECKSUM_EN
          next_state = csum_ok ? RUN : EMPTY;
`else
          next_state = RUN;
`endif
        end
      end
      RUN: begin
        if (cfg_start) next_state = LOAD;
      end
      default: next_state = EMPTY;
    endcase
  end

  // Load bookkeeping: word counter, completion pulse and programmed flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt       <= '0;
      cfg_done   <= 1'b0;
      programmed <= 1'b0;
`ifdef LUT_CFG_CHECKSUM_EN
      cfg_err    <= 1'b0;
      csum       <= '0;
`endif
    end else begin
      cfg_done <= 1'b0;
`ifdef LUT_CFG_CHECKSUM_EN
      cfg_err  <= 1'b0;
`endif
      if (cfg_start) begin
        wcnt       <= '0;
        programmed <= 1'b0;
`ifdef LUT_CFG_CHECKSUM_EN
        csum       <= '0;
`endif
      end else if (accept) begin
        wcnt <= wcnt + WCNT_W'(1);
`ifdef LUT_CFG_CHECKSUM_EN
        if (data_word) csum <= csum ^ cfg_data;
        if (last_word) begin
          if (csum_ok) begin
            cfg_done   <= 1'b1;
            programmed <= 1'b1;
          end else begin
            cfg_err    <= 1'b1;
          end
        end
`else
        if (last_word) begin
          cfg_done   <= 1'b1;
          programmed <= 1'b1;
        end
`endif
      end
    end
  end

  // Lookup pipeline: one registered read per cycle, only while the table is valid
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      if ((state == RUN) && in_valid && !cfg_start) begin
        out_valid <= 1'b1;
        out_data  <= table_mem[in_data];
      end
    end
  end

endmodule

// File: doc/lut_neuron_prog.md
Name: lut_neuron_prog

Overview:
- Runtime-programmable counterpart of the generated fixed-ROM LUT neurons.
- A configuration writer streams a truth table into a distributed-RAM table of 2^IN_BITS entries, each OUT_BITS wide. The block then serves registered lookups from that table.
- Used on the HGCAL autoencoder pipecleaner so that retrained layer-0 neurons can be reloaded without resynthesis.

Parameters:
- IN_BITS, 8, lookup address width (4 inputs x 2 bits); table depth = 2^IN_BITS.
- OUT_BITS, 2, entry width.
- CFG_W, 16, configuration word width; must be a multiple of OUT_BITS. Entries per word EPW = CFG_W/OUT_BITS.
- NWORDS, derived = 2^IN_BITS / EPW (32 at defaults); not overridable.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cfg_start  in  1  pulse: begin (re)load of the table
- cfg_valid  in  1  config word valid
- cfg_data  in  CFG_W  config word
- cfg_ready  out  1  block accepts config word
- cfg_done  out  1  one-cycle pulse: table load complete
- programmed  out  1  table valid, lookups enabled
- in_valid  in  1  lookup request valid
- in_data  in  IN_BITS  lookup address
- out_valid  out  1  lookup result valid
- out_data  out  OUT_BITS  lookup result

Behaviour:
- Reset values:
  - state=EMPTY, word counter wcnt=0.
  - cfg_ready=0, cfg_done=0, programmed=0, out_valid=0, out_data=0.
  - Table contents are not reset.
- States: EMPTY, LOAD, RUN.
- EMPTY:
  - cfg_ready=0; lookups ignored.
  - cfg_start -> LOAD next cycle.
- LOAD:
  - cfg_ready=1.
  - A word is accepted on cycle edges where cfg_valid & cfg_ready.
  - Accepted word k writes entries k*EPW+j, j=0..EPW-1, from cfg_data[j*OUT_BITS +: OUT_BITS]. Entry 0 is in the LSBs.
  - wcnt increments per accepted word.
  - On acceptance of word NWORDS-1: next cycle state=RUN, cfg_ready=0, cfg_done=1 for exactly one cycle, programmed=1.
  - cfg_valid while cfg_ready=0 is ignored; no word is consumed.
- RUN:
  - Lookup latency is 1 cycle. in_valid at edge n gives out_valid=1 and out_data=table[in_data] after edge n, held for one cycle.
  - Back-to-back requests are supported at full rate.
  - in_valid=0 -> out_valid=0; out_data holds its last value.
- cfg_start in RUN or LOAD:
  - Next cycle state=LOAD, wcnt=0, programmed=0, out_valid=0.
  - Any lookup issued in the same cycle as cfg_start is dropped.
  - A config word valid in the same cycle as cfg_start is NOT accepted.
- Table writes and reads never overlap, because lookups are disabled outside RUN.
- rst mid-LOAD or mid-RUN:
  - Returns to EMPTY with programmed=0; any partial load is abandoned.
  - A full reload is required before lookups resume.
- wcnt is ceil(log2(NWORDS+1)) bits wide and never wraps. Extra words after the last are not accepted because cfg_ready=0.

Optional Feature:
- Macro: LUT_CFG_CHECKSUM_EN.
- Defined:
  - LOAD expects NWORDS+1 words; the last word is a checksum equal to the XOR of all NWORDS data words.
  - On acceptance of the checksum word:
    - Match -> RUN, cfg_done pulse, programmed=1.
    - Mismatch -> EMPTY, cfg_err pulses 1 cycle, programmed=0.
  - Adds output port cfg_err (1 bit, reset 0).
- Undefined: no checksum word, no cfg_err port; load completes after NWORDS words.

Test Plan:
- Reset then in_valid=1, in_data=8'hC0 -> out_valid stays 0, programmed=0, cfg_ready=0.
- cfg_start, then 32 words with word k=16'h0000 except word 24=16'h0003 (entry 192=2'b11); no stalls -> cfg_done pulses exactly once, one cycle after the 32nd acceptance; lookup 8'hC0 -> out_data=2'b11 one cycle later; lookup 8'hC1 -> 2'b00.
- Load with cfg_valid toggled 1/0 each cycle plus random gaps -> exactly 32 words consumed; table identical to the no-stall load; throughput of back-to-back lookups over all 256 addresses is one result per cycle, all matching the model.
- In RUN, assert cfg_start together with in_valid and cfg_valid -> lookup dropped (out_valid=0), word not consumed, programmed=0 next cycle, wcnt=0.
- Assert rst after 10 words of a load -> state EMPTY, cfg_ready=0; a following full load of 32 words programs the table correctly.
- With LUT_CFG_CHECKSUM_EN: correct checksum -> programmed=1; checksum with bit 0 flipped -> cfg_err pulse, programmed=0, lookups ignored.
